// File: rtl/ula_seq.sv
// Sequential ALU: one operation per start/done handshake.
// Simple ops finish in one cycle. Shifts move one bit per cycle and multiply
// retires one multiplier bit per cycle, which keeps wide shifters and
// multipliers off the datapath critical path.
module ula_seq #(
  parameter int unsigned W = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         start,
  input  logic [2:0]   sinal,
  input  logic [W-1:0] A,
  input  logic [W-1:0] Bus,
  output logic [W-1:0] G,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CNTW = $clog2(W) + 1;
  localparam logic [W-1:0]    WLim   = W'(W);
  // The accept edge already retires the first multiplier bit
  localparam logic [CNTW-1:0] MulCnt = CNTW'(W - 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpOr  = 3'b010;
  localparam logic [2:0] OpSlt = 3'b011;
  localparam logic [2:0] OpSll = 3'b100;
  localparam logic [2:0] OpSrl = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;

  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic            dir_q, dir_d;
  logic [W-1:0]    g_q, g_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;

  logic [W-1:0]    fast_res, shl_a, shr_a, shift_res, mul_sum, wr_val;
  logic            shift_fast, wr;

  // Single-cycle results and per-step datapath values
  always_comb begin
    shl_a      = A << 1;
    shr_a      = A >> 1;
    shift_res  = dir_q ? (acc_q >> 1) : (acc_q << 1);
    mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
    // A shift by 0 or 1 has a one-cycle latency either way, so it skips the loop
    shift_fast = (Bus <= W'(1)) || (Bus >= WLim);
    unique case (sinal)
      OpAdd:   fast_res = A + Bus;
      OpSub:   fast_res = A - Bus;
      OpOr:    fast_res = A | Bus;
      OpSlt:   fast_res = {{(W-1){1'b0}}, (A < Bus)};
      OpSll:   fast_res = (Bus >= WLim) ? '0 : ((Bus == '0) ? A : shl_a);
      OpSrl:   fast_res = (Bus >= WLim) ? '0 : ((Bus == '0) ? A : shr_a);
      default: fast_res = '0;
    endcase
  end

  // Next-state logic: accept, iterate, and retire an operation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    dir_d    = dir_q;
    g_d      = g_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    wr       = 1'b0;
    wr_val   = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (sinal)
            OpSll, OpSrl: begin
              if (shift_fast) begin
                wr     = 1'b1;
                wr_val = fast_res;
              end else begin
                acc_d   = (sinal == OpSrl) ? shr_a : shl_a;
                dir_d   = (sinal == OpSrl);
                cnt_d   = Bus[CNTW-1:0] - 1'b1;
                state_d = StShift;
              end
            end
            OpMul: begin
              acc_d    = Bus[0] ? A : '0;
              mcand_d  = A << 1;
              mplier_d = Bus >> 1;
              cnt_d    = MulCnt;
              state_d  = StMul;
            end
            default: begin
              wr     = 1'b1;
              wr_val = fast_res;
            end
          endcase
        end
      end
      StShift: begin
        acc_d = shift_res;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) begin
          wr      = 1'b1;
          wr_val  = shift_res;
          state_d = StIdle;
        end
      end
      StMul: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) begin
          wr      = 1'b1;
          wr_val  = mul_sum;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr) begin
      g_d    = wr_val;
      zero_d = (wr_val == '0);
      done_d = 1'b1;
    end
  end

  // State and result registers; reset aborts any operation in flight
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      dir_q    <= 1'b0;
      g_q      <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      dir_q    <= dir_d;
      g_q      <= g_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign G    = g_q;
  assign zero = zero_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (W=16): directed operations with literal
// expectations plus a cycle-by-cycle comparison against a result/latency model.
module tb_ula_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   sinal = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] Bus = '0;
  logic [W-1:0] G;
  logic         zero, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  ula_seq #(.W(W)) dut (
    .Clock (clk),
    .Resetn(rst_n),
    .start (start),
    .sinal (sinal),
    .A     (A),
    .Bus   (Bus),
    .G     (G),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result of an operation, straight from the opcode table
  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = a * b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return (a < b) ? W'(1) : W'(0);
      3'd4: return (b >= W) ? '0 : (a << b);
      3'd5: return (b >= W) ? '0 : (a >> b);
      3'd6: return p[W-1:0];
      default: return '0;
    endcase
  endfunction

  // Cycles from start to done
  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] b);
    if (op == 3'd4 || op == 3'd5) return (b == 0 || b >= W) ? 1 : int'(b);
    if (op == 3'd6) return W;
    return 1;
  endfunction

  // Model: remaining cycles of the operation in flight and the visible result
  logic [W-1:0] m_g = '0;
  logic [W-1:0] m_res = '0;
  bit           m_done = 1'b0;
  int           m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_g = '0; m_res = '0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin m_g = m_res; m_done = 1'b1; end
      end else if (start) begin
        m_res = ref_res(sinal, A, Bus);
        m_rem = ref_lat(sinal, Bus) - 1;
        if (m_rem == 0) begin m_g = m_res; m_done = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_g", G, m_g);
      check("model_zero", zero, m_g == '0);
      check("model_busy", busy, m_rem > 0);
      check("model_done", done, m_done);
    end
  end

  // Issue one op, optionally toggling start/operands while busy, then wait for done
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_g, input int exp_lat,
                        input bit noisy);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; sinal = op; A = a; Bus = b;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 40) begin
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
      end else begin
        if (noisy) begin
          start = 1'($urandom_range(0, 1));
          sinal = 3'($urandom_range(0, 7));
          A = W'($urandom);
          Bus = W'($urandom);
        end
        @(negedge clk);
        n++;
      end
    end
    check({name, "_seen"}, seen, 1);
    if (seen) begin
      check({name, "_lat"}, n, exp_lat);
      check({name, "_g"}, G, exp_g);
      check({name, "_zero"}, zero, exp_g == '0);
    end
  endtask

  initial begin
    int n;
    int dones;

    repeat (2) @(negedge clk);
    check("rst_g", G, 16'h0000);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1, 1'b0);
    run_op("sub_zero", 3'd1, 16'h0005, 16'h0005, 16'h0000, 1, 1'b0);
    run_op("or",       3'd2, 16'h00F0, 16'h0F0F, 16'h0FFF, 1, 1'b0);
    run_op("slt_lt",   3'd3, 16'h0003, 16'h0004, 16'h0001, 1, 1'b0);
    run_op("slt_uns",  3'd3, 16'hFFFF, 16'h0001, 16'h0000, 1, 1'b0);
    run_op("op7",      3'd7, 16'h1234, 16'h5678, 16'h0000, 1, 1'b0);
    run_op("sll4",     3'd4, 16'h0001, 16'h0004, 16'h0010, 4, 1'b1);
    run_op("sll0",     3'd4, 16'h00AB, 16'h0000, 16'h00AB, 1, 1'b0);
    run_op("sll16",    3'd4, 16'h00AB, 16'h0010, 16'h0000, 1, 1'b0);
    run_op("sll1",     3'd4, 16'h0003, 16'h0001, 16'h0006, 1, 1'b0);
    run_op("srl15",    3'd5, 16'h8000, 16'h000F, 16'h0001, 15, 1'b1);
    run_op("srl3",     3'd5, 16'hF0F0, 16'h0003, 16'h1E1E, 3, 1'b0);
    run_op("mul",      3'd6, 16'h0012, 16'h0010, 16'h0120, 16, 1'b1);
    run_op("mul_max",  3'd6, 16'hFFFF, 16'hFFFF, 16'h0001, 16, 1'b0);

    // start held high through a MUL: next op accepted on the done cycle
    @(negedge clk);
    start = 1'b1; sinal = 3'd6; A = 16'h0003; Bus = 16'h0005;
    @(negedge clk);
    sinal = 3'd0; A = 16'h0001; Bus = 16'h0002;
    n = 1;
    while (!done && n <= 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_mul_lat", n, 16);
    check("b2b_mul_g", G, 16'h000F);
    @(negedge clk);
    start = 1'b0;
    check("b2b_add_done", done, 1);
    check("b2b_add_g", G, 16'h0003);

    // Reset in the middle of a MUL aborts it without a done
    @(negedge clk);
    start = 1'b1; sinal = 3'd6; A = 16'h0102; Bus = 16'h0304;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_g", G, 16'h0000);
    check("midrst_zero", zero, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    repeat (24) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);

    run_op("post_rst", 3'd0, 16'h1000, 16'h0234, 16'h1234, 1, 1'b0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
